// File: rtl/pl_elastic_reg.sv
// Two-entry elastic pipeline stage (main + skid) with registered valid/ready, flush and NOP bubble.
// Optional stall/drop statistics counters are built when PL_ELASTIC_STATS_EN is defined.
module pl_elastic_reg #(
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      NOP_VALUE = '0,
    parameter int unsigned           CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    // Handshake outputs decode only registered state, so no input reaches them combinationally.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                    main_d  = NOP_VALUE;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                    skid_d  = NOP_VALUE;
                end
            end
            default: begin
                state_d = EMPTY;
                main_d  = NOP_VALUE;
                skid_d  = NOP_VALUE;
            end
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PL_ELASTIC_STATS_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W:0]   stall_sum, drop_sum;
    logic             stall_inc;
    logic [1:0]       drop_inc;

    assign stall_inc = out_valid & ~out_ready & ~flush;

    // Entries lost to a flush: those held, less one leaving downstream, plus one arriving.
    always_comb begin
        drop_inc = 2'd0;
        if (flush) begin
            drop_inc = occupancy - {1'b0, out_fire} + {1'b0, in_fire};
        end
    end

    assign stall_sum = {1'b0, stall_q} + {{CNT_W{1'b0}}, stall_inc};
    assign drop_sum  = {1'b0, drop_q} + {{(CNT_W-1){1'b0}}, drop_inc};

    always_comb begin
        stall_d = stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
        drop_d  = drop_sum[CNT_W]  ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            stall_q <= stall_d;
            drop_q  <= drop_d;
        end
    end

    assign stall_cnt = stall_q;
    assign drop_cnt  = drop_q;
`else
    assign stall_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_pl_elastic_reg.sv
// Directed and scoreboard-checked bench for pl_elastic_reg (WIDTH=8, non-zero NOP, CNT_W=2).
module tb_pl_elastic_reg;

    localparam int unsigned   WIDTH = 8;
    localparam logic [7:0]    NOP   = 8'hE5;
    localparam int unsigned   CNT_W = 2;
    localparam int unsigned   CMAX  = 3;
`ifdef PL_ELASTIC_STATS_EN
    localparam bit            STATS = 1'b1;
`else
    localparam bit            STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt, drop_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    pl_elastic_reg #(
        .WIDTH     (WIDTH),
        .NOP_VALUE (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] st(input int unsigned v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    logic [7:0]  q[$];
    int unsigned m_stall, m_drop;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'(NOP));
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // pass-through
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        in_data = 8'h11; tick();
        chk("pt_v1", 32'(out_valid), 32'd1);
        chk("pt_d1", 32'(out_data), 32'h11);
        in_data = 8'h22; tick();
        chk("pt_d2", 32'(out_data), 32'h22);
        in_data = 8'h33; tick();
        chk("pt_d3", 32'(out_data), 32'h33);
        chk("pt_occ3", 32'(occupancy), 32'd1);
        in_valid = 1'b0; tick();
        chk("pt_empty_v", 32'(out_valid), 32'd0);
        chk("pt_empty_d", 32'(out_data), 32'(NOP));

        // backpressure
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h0A; tick();
        chk("bp_a_data", 32'(out_data), 32'h0A);
        chk("bp_a_rdy", 32'(in_ready), 32'd1);
        in_data = 8'h0B; tick();
        chk("bp_full_occ", 32'(occupancy), 32'd2);
        chk("bp_full_rdy", 32'(in_ready), 32'd0);
        chk("bp_full_head", 32'(out_data), 32'h0A);
        in_data = 8'h0C; tick();
        chk("bp_c_rej_occ", 32'(occupancy), 32'd2);
        chk("bp_c_rej_head", 32'(out_data), 32'h0A);
        chk("bp_stall", 32'(stall_cnt), st(2));
        out_ready = 1'b1; tick();
        chk("bp_out_b", 32'(out_data), 32'h0B);
        chk("bp_release_rdy", 32'(in_ready), 32'd1);
        tick();
        chk("bp_out_c", 32'(out_data), 32'h0C);
        chk("bp_out_c_occ", 32'(occupancy), 32'd1);
        in_valid = 1'b0; tick();
        chk("bp_drain_v", 32'(out_valid), 32'd0);

        // simultaneous fire in ONE
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h05; tick();
        in_data = 8'h06; out_ready = 1'b1;
        chk("sf_head5", 32'(out_data), 32'h05);
        chk("sf_v5", 32'(out_valid), 32'd1);
        tick();
        chk("sf_head6", 32'(out_data), 32'h06);
        chk("sf_occ", 32'(occupancy), 32'd1);
        in_valid = 1'b0; tick();

        // flush in FULL
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h21; tick();
        in_data = 8'h22; tick();
        chk("fl_pre_occ", 32'(occupancy), 32'd2);
        flush = 1'b1; in_data = 8'h23; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_v", 32'(out_valid), 32'd0);
        chk("fl_d", 32'(out_data), 32'(NOP));
        chk("fl_rdy", 32'(in_ready), 32'd1);
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_drop", 32'(drop_cnt), st(2));
        tick();
        chk("fl_stays_empty", 32'(out_valid), 32'd0);

        // stall counter saturation
        rst = 1'b1; tick();
        rst = 1'b0; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("sat_stall_%0d", i), 32'(stall_cnt), st((i + 1 < 3) ? i + 1 : 3));
        end
        chk("sat_drop_clr", 32'(drop_cnt), 32'd0);

        // random with scoreboard
        rst = 1'b1; tick();
        rst = 1'b0;
        q.delete();
        m_stall = 0;
        m_drop  = 0;
        for (int c = 0; c < 400; c++) begin
            bit mv, mr, inf, outf;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 11) == 0);
            in_data   = 8'($urandom_range(0, 255));
            #1;
            mv = (q.size() > 0);
            mr = (q.size() < 2);
            chk("rnd_valid", 32'(out_valid), 32'(mv));
            chk("rnd_ready", 32'(in_ready), 32'(mr));
            chk("rnd_occ", 32'(occupancy), 32'(q.size()));
            chk("rnd_data", 32'(out_data), mv ? 32'(q[0]) : 32'(NOP));
            chk("rnd_stall", 32'(stall_cnt), st(m_stall));
            chk("rnd_drop", 32'(drop_cnt), st(m_drop));
            inf  = in_valid & mr;
            outf = mv & out_ready;
            if (flush) begin
                m_drop = m_drop + q.size() - 32'(outf) + 32'(inf);
                if (m_drop > CMAX) m_drop = CMAX;
                q.delete();
            end else begin
                if (mv && !out_ready && m_stall < CMAX) m_stall++;
                if (outf) void'(q.pop_front());
                if (inf) q.push_back(in_data);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
